// File: rtl/apb_pkg.sv
// Shared defaults and state encoding for the APB master bridge and its helpers.
package apb_pkg;

    localparam int APB_AW  = 9;
    localparam int APB_DW  = 8;
    localparam int APB_TMO = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB bus bundle between the bridge (master) and the two-slave fabric (slave).
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int AW = APB_AW,
    parameter int DW = APB_DW
) ();

    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel1, psel2, penable,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel1, psel2, penable,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states; expired flags the last permitted wait cycle.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TMO = APB_TMO
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TMO) + 1;

    logic [CW-1:0] r_count;

    assign expired = (r_count == CW'(TMO - 1));

    // Saturates at the expiry value so a stuck enable cannot wrap the count.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns single-cycle transfer requests into SETUP/ACCESS
// bus cycles toward two slaves, with wait-state timeout and sticky error.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int AW  = APB_AW,
    parameter int DW  = APB_DW,
    parameter int TMO = APB_TMO
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out,
    output logic          slverr_out,
    apb_master_bridge_if.master apb
);

    apb_state_e    r_state;
    apb_state_e    w_nextState;
    logic [AW-1:0] r_paddr;
    logic [DW-1:0] r_pwdata;
    logic          r_pwrite;
    logic [DW-1:0] r_rdata;
    logic          r_slverr;

    logic w_accept;
    logic w_complete;
    logic w_timeout;
    logic w_timerClear;
    logic w_timerEn;
    logic w_expired;

    apb_wait_timer #(.TMO(TMO)) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (w_timerClear),
        .enable  (w_timerEn),
        .expired (w_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Requests are only looked at in IDLE and on the completing ACCESS cycle.
    always_comb begin
        w_nextState  = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_timerClear = 1'b0;
        w_timerEn    = 1'b0;
        case (r_state)
            IDLE: begin
                if (transfer) begin
                    w_nextState = SETUP;
                    w_accept    = 1'b1;
                end
            end
            SETUP: begin
                w_nextState  = ACCESS;
                w_timerClear = 1'b1;
            end
            ACCESS: begin
                if (apb.pready) begin
                    w_complete = 1'b1;
                    if (transfer) begin
                        w_nextState = SETUP;
                        w_accept    = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_timerEn = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else if (w_accept) begin
            r_paddr  <= read_write ? apb_read_paddr : apb_write_paddr;
            r_pwdata <= apb_write_data;
            r_pwrite <= ~read_write;
        end
    end

    // An error from the finishing transfer outranks the clear from a request
    // accepted on the same edge, so a back-to-back error is never lost.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rdata  <= '0;
            r_slverr <= 1'b0;
        end else begin
            if (w_complete && !r_pwrite) begin
                r_rdata <= apb.prdata;
            end
            if (w_timeout || (w_complete && apb.pslverr)) begin
                r_slverr <= 1'b1;
            end else if (w_accept) begin
                r_slverr <= 1'b0;
            end
        end
    end

    assign apb.paddr         = r_paddr;
    assign apb.pwdata        = r_pwdata;
    assign apb.pwrite        = r_pwrite;
    assign apb.psel1         = (r_state != IDLE) && !r_paddr[AW-1];
    assign apb.psel2         = (r_state != IDLE) &&  r_paddr[AW-1];
    assign apb.penable       = (r_state == ACCESS);
    assign apb_read_data_out = r_rdata;
    assign slverr_out        = r_slverr;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scenario bench for apb_master_bridge: per-feature tasks plus a scoreboard
// that checks every completed bus transfer against the queued request.
module tb_apb_master_bridge;

    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int TMO = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
    } expTxn_t;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          transfer = 1'b0;
    logic          read_write = 1'b0;
    logic [AW-1:0] apb_write_paddr = '0;
    logic [DW-1:0] apb_write_data = '0;
    logic [AW-1:0] apb_read_paddr = '0;
    logic [DW-1:0] apb_read_data_out;
    logic          slverr_out;

    int            testsRun = 0;
    int            testsFailed = 0;
    logic [DW-1:0] expRdata = '0;
    expTxn_t       expQ[$];
    expTxn_t       monExp;

    apb_master_bridge_if #(.AW(AW), .DW(DW)) bus ();

    apb_master_bridge #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .slverr_out        (slverr_out),
        .apb               (bus.master)
    );

    always #5 pclk = ~pclk;

    // Scoreboard: a completing ACCESS cycle must match the oldest queued request.
    always @(negedge pclk) begin
        if (presetn && (bus.psel1 || bus.psel2) && bus.penable && bus.pready) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL scoreboard_unexpected: paddr=%h pwrite=%b with nothing queued",
                         bus.paddr, bus.pwrite);
            end else begin
                monExp = expQ.pop_front();
                if ({bus.paddr, bus.pwrite, bus.psel2, bus.psel1} !==
                    {monExp.addr, monExp.write, monExp.addr[AW-1], !monExp.addr[AW-1]} ||
                    (monExp.write && bus.pwdata !== monExp.wdata)) begin
                    testsFailed++;
                    $display("[TB] FAIL scoreboard_txn: got addr=%h wr=%b sel2/1=%b%b wdata=%h, want addr=%h wr=%b wdata=%h",
                             bus.paddr, bus.pwrite, bus.psel2, bus.psel1, bus.pwdata,
                             monExp.addr, monExp.write, monExp.wdata);
                end
            end
        end
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic applyStimulus(input logic rw, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                 input logic err);
        transfer        = 1'b1;
        read_write      = rw;
        apb_write_paddr = rw ? ~addr : addr;
        apb_read_paddr  = rw ? addr : ~addr;
        apb_write_data  = wdata;
        bus.prdata      = rdata;
        bus.pslverr     = err;
        bus.pready      = 1'b0;
    endtask

    // Runs one request to its end; request inputs are scrambled after acceptance.
    task automatic runTransfer(input logic rw, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input int waits,
                               input logic [DW-1:0] rdata, input logic err,
                               output int selCycles, output logic errAfterAccept);
        int accessSamples = 0;
        bit done = 0;
        selCycles = 0;
        applyStimulus(rw, addr, wdata, rdata, err);
        if (waits < TMO) expQ.push_back('{addr, !rw, wdata});
        tick();
        errAfterAccept  = slverr_out;
        transfer        = 1'b0;
        read_write      = ~rw;
        apb_write_paddr = '1;
        apb_read_paddr  = '0;
        apb_write_data  = '1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.psel1 || bus.psel2) begin
                selCycles++;
                if (bus.penable) accessSamples++;
                bus.pready = (accessSamples > waits);
                tick();
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL transfer_bound: still selected after 40 cycles, want return to IDLE");
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
    endtask

    task automatic test_reset;
        testsRun++;
        if ({bus.paddr, bus.pwdata, bus.pwrite, bus.psel1, bus.psel2, bus.penable} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_bus: paddr=%h pwdata=%h pwrite=%b psel=%b%b penable=%b, want all 0",
                     bus.paddr, bus.pwdata, bus.pwrite, bus.psel2, bus.psel1, bus.penable);
        end
        testsRun++;
        if (apb_read_data_out !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_rdata: got %h, want 00", apb_read_data_out);
        end
        testsRun++;
        if (slverr_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_slverr: got %b, want 0", slverr_out);
        end
    endtask

    task automatic test_write;
        int   sel;
        logic e;
        runTransfer(1'b0, 9'h0A5, 8'h3C, 0, 8'hEE, 1'b0, sel, e);
        testsRun++;
        if (sel !== 2) begin
            testsFailed++;
            $display("[TB] FAIL write_latency: psel cycles %0d, want 2", sel);
        end
        testsRun++;
        if (apb_read_data_out !== expRdata) begin
            testsFailed++;
            $display("[TB] FAIL write_keeps_rdata: got %h, want %h", apb_read_data_out, expRdata);
        end
    endtask

    task automatic test_read_wait;
        int   sel;
        logic e;
        runTransfer(1'b1, 9'h105, 8'h5A, 3, 8'h77, 1'b0, sel, e);
        expRdata = 8'h77;
        testsRun++;
        if (sel !== 5) begin
            testsFailed++;
            $display("[TB] FAIL read_wait_psel2: psel cycles %0d, want 5", sel);
        end
        testsRun++;
        if (apb_read_data_out !== expRdata) begin
            testsFailed++;
            $display("[TB] FAIL read_wait_data: got %h, want %h", apb_read_data_out, expRdata);
        end
    endtask

    task automatic test_back_to_back;
        applyStimulus(1'b0, 9'h010, 8'hAB, 8'h99, 1'b0);
        bus.pready = 1'b1;
        expQ.push_back('{9'h010, 1'b1, 8'hAB});
        tick();
        testsRun++;
        if ({bus.psel1, bus.psel2, bus.penable, bus.paddr} !== {3'b100, 9'h010}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_setup1: psel1/2/en=%b%b%b paddr=%h, want 100 010",
                     bus.psel1, bus.psel2, bus.penable, bus.paddr);
        end
        read_write     = 1'b1;
        apb_read_paddr = 9'h110;
        expQ.push_back('{9'h110, 1'b0, 8'hAB});
        tick();
        testsRun++;
        if ({bus.psel1, bus.psel2, bus.penable} !== 3'b101) begin
            testsFailed++;
            $display("[TB] FAIL b2b_access1: psel1/2/en=%b%b%b, want 101",
                     bus.psel1, bus.psel2, bus.penable);
        end
        tick();
        testsRun++;
        if ({bus.psel1, bus.psel2, bus.penable, bus.pwrite, bus.paddr} !== {4'b0100, 9'h110}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_setup2: psel1/2/en/wr=%b%b%b%b paddr=%h, want 0100 110",
                     bus.psel1, bus.psel2, bus.penable, bus.pwrite, bus.paddr);
        end
        transfer = 1'b0;
        tick();
        tick();
        expRdata = 8'h99;
        bus.pready = 1'b0;
        testsRun++;
        if ({bus.psel1, bus.psel2, apb_read_data_out} !== {2'b00, expRdata}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_end: psel=%b%b rdata=%h, want 00 %h",
                     bus.psel1, bus.psel2, apb_read_data_out, expRdata);
        end
    endtask

    task automatic test_timeout;
        int   sel;
        logic e;
        runTransfer(1'b1, 9'h1F0, 8'h00, 100, 8'h13, 1'b0, sel, e);
        testsRun++;
        if (sel !== TMO + 1) begin
            testsFailed++;
            $display("[TB] FAIL timeout_cycles: psel cycles %0d, want %0d", sel, TMO + 1);
        end
        testsRun++;
        if ({slverr_out, apb_read_data_out} !== {1'b1, expRdata}) begin
            testsFailed++;
            $display("[TB] FAIL timeout_flags: slverr=%b rdata=%h, want 1 %h",
                     slverr_out, apb_read_data_out, expRdata);
        end
        runTransfer(1'b0, 9'h020, 8'h42, 0, 8'h00, 1'b0, sel, e);
        testsRun++;
        if (e !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_clear: slverr after accept %b, want 0", e);
        end
    endtask

    task automatic test_slverr;
        int   sel;
        logic e;
        runTransfer(1'b1, 9'h0C0, 8'h00, 0, 8'h55, 1'b1, sel, e);
        expRdata = 8'h55;
        testsRun++;
        if ({slverr_out, apb_read_data_out} !== {1'b1, expRdata}) begin
            testsFailed++;
            $display("[TB] FAIL slverr_read: slverr=%b rdata=%h, want 1 %h",
                     slverr_out, apb_read_data_out, expRdata);
        end
    endtask

    task automatic test_reset_mid_access;
        int   sel;
        logic e;
        applyStimulus(1'b1, 9'h105, 8'h00, 8'hAA, 1'b0);
        tick();
        transfer = 1'b0;
        tick();
        tick();
        presetn = 1'b0;
        #1;
        testsRun++;
        if ({bus.paddr, bus.pwdata, bus.pwrite, bus.psel1, bus.psel2, bus.penable,
             apb_read_data_out, slverr_out} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: paddr=%h psel=%b%b en=%b rdata=%h slverr=%b, want all 0",
                     bus.paddr, bus.psel2, bus.psel1, bus.penable, apb_read_data_out, slverr_out);
        end
        bus.pready = 1'b1;
        tick();
        tick();
        bus.pready = 1'b0;
        presetn    = 1'b1;
        tick();
        expRdata = 8'h00;
        testsRun++;
        if (apb_read_data_out !== expRdata) begin
            testsFailed++;
            $display("[TB] FAIL reset_rdata_held: got %h, want 00", apb_read_data_out);
        end
        runTransfer(1'b0, 9'h0A5, 8'h3C, 0, 8'hEE, 1'b0, sel, e);
        testsRun++;
        if ({sel, apb_read_data_out} !== {32'd2, expRdata}) begin
            testsFailed++;
            $display("[TB] FAIL reset_restart: psel cycles %0d rdata=%h, want 2 00", sel, apb_read_data_out);
        end
    endtask

    task automatic checkOutput;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d requests never completed, want 0", expQ.size());
        end
    endtask

    initial begin
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        tick();
        tick();
        test_reset();
        presetn = 1'b1;
        tick();
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_slverr();
        test_reset_mid_access();
        tick();
        checkOutput();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
